fetch_pc_unit: RTL and testbench

Holds the architectural program-counter state and instruction-side registers for the multicycle MIPS core. It sits between unified memory and the control FSM and decodes IR fields (Op, Funct, rs, rt, rd, imm, jump index) for that FSM. It consumes the FSM strobes PC_Write, Branch, PC_Src, PC_J, IR_Write and IorD, plus the ALU result and Zero flag. It also provides a link register for JAL, a sticky alignment error and a retired-instruction counter.

---
 rtl/fetch_pc_unit.sv | 101 ++++++++++
 tb/tb_fetch_pc_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter, instruction register and fetch-side state
// for the multicycle MIPS datapath.
module fetch_pc_unit #(
    parameter int unsigned          WIDTH    = 32,
    parameter logic [WIDTH-1:0]     RESET_PC = 32'h0040_0000,
    parameter int unsigned          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PC_Write,
    input  logic             Branch,
    input  logic             PC_Src,
    input  logic             PC_J,
    input  logic             IR_Write,
    input  logic             IorD,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] pc_q,
    output logic [WIDTH-1:0] ir_q,
    output logic [WIDTH-1:0] mdr_q,
    output logic [WIDTH-1:0] aluout_q,
    output logic [WIDTH-1:0] link_q,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [15:0]      imm,
    output logic [25:0]      jidx,
    output logic             align_err,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [WIDTH-1:0] jtgt;
    logic [WIDTH-1:0] pc_next;
    logic             pc_en;

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] ir_d;
    logic [WIDTH-1:0] link_d;
    logic             err_d;
    logic [CNT_W-1:0] cnt_d;

    // pc_q already points past the jump, so its top bits give the region
    assign jtgt     = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
    assign pc_next  = PC_J ? (PC_Src ? aluout_q : alu_result) : jtgt;
    assign pc_en    = PC_Write | (Branch & alu_zero);
    assign mem_addr = IorD ? aluout_q : pc_q;

    assign op    = ir_q[31:26];
    assign funct = ir_q[5:0];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign imm   = ir_q[15:0];
    assign jidx  = ir_q[25:0];

    // Next-state selection for PC, IR, link, error flag and counter
    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        link_d = link_q;
        err_d  = align_err;
        cnt_d  = instr_cnt;
        if (pc_en) begin
            pc_d = pc_next;
            if (pc_next[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
        end
        if (IR_Write) begin
            ir_d   = mem_rdata;
            cnt_d  = instr_cnt + 1'b1;
            link_d = pc_en ? pc_next : pc_q;
        end
    end

    // State registers; mdr and aluout capture unconditionally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            aluout_q  <= '0;
            link_q    <= '0;
            align_err <= 1'b0;
            instr_cnt <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mem_rdata;
            aluout_q  <= alu_result;
            link_q    <= link_d;
            align_err <= err_d;
            instr_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed literals plus
// randomized strobes checked against a behavioural model.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PC_Write = 0, Branch = 0, PC_Src = 0, PC_J = 0;
    logic        IR_Write = 0, IorD = 0, alu_zero = 0;
    logic [31:0] alu_result = 0, mem_rdata = 0;

    logic [31:0] mem_addr, pc_q, ir_q, mdr_q, aluout_q, link_q;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic        align_err;
    logic [31:0] instr_cnt;

    logic [31:0] b_mem_addr, b_pc, b_ir, b_mdr, b_aluout, b_link;
    logic [5:0]  b_op, b_funct;
    logic [4:0]  b_rs, b_rt, b_rd;
    logic [15:0] b_imm;
    logic [25:0] b_jidx;
    logic        b_err;
    logic [3:0]  b_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk(clk), .rst(rst), .PC_Write(PC_Write), .Branch(Branch),
        .PC_Src(PC_Src), .PC_J(PC_J), .IR_Write(IR_Write), .IorD(IorD),
        .alu_result(alu_result), .alu_zero(alu_zero), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .pc_q(pc_q), .ir_q(ir_q), .mdr_q(mdr_q),
        .aluout_q(aluout_q), .link_q(link_q), .op(op), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .imm(imm), .jidx(jidx),
        .align_err(align_err), .instr_cnt(instr_cnt)
    );

    fetch_pc_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .PC_Write(PC_Write), .Branch(Branch),
        .PC_Src(PC_Src), .PC_J(PC_J), .IR_Write(IR_Write), .IorD(IorD),
        .alu_result(alu_result), .alu_zero(alu_zero), .mem_rdata(mem_rdata),
        .mem_addr(b_mem_addr), .pc_q(b_pc), .ir_q(b_ir), .mdr_q(b_mdr),
        .aluout_q(b_aluout), .link_q(b_link), .op(b_op), .funct(b_funct),
        .rs(b_rs), .rt(b_rt), .rd(b_rd), .imm(b_imm), .jidx(b_jidx),
        .align_err(b_err), .instr_cnt(b_cnt)
    );

    // Behavioural model state
    logic [31:0] m_pc, m_ir, m_mdr, m_alu, m_link, m_cnt;
    logic [3:0]  m_cnt4;
    logic        m_err;

    function automatic logic take_pc();
        return PC_Write || (Branch && alu_zero);
    endfunction

    function automatic logic [31:0] target();
        if (!PC_J) return {m_pc[31:28], m_ir[25:0], 2'b00};
        if (PC_Src) return m_alu;
        return alu_result;
    endfunction

    // Model advances on the same edges as the design
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc <= 32'h0040_0000; m_ir <= 0; m_mdr <= 0; m_alu <= 0;
            m_link <= 0; m_cnt <= 0; m_cnt4 <= 0; m_err <= 0;
        end else begin
            m_mdr <= mem_rdata;
            m_alu <= alu_result;
            if (take_pc()) begin
                m_pc <= target();
                if (target() % 4 != 0) m_err <= 1'b1;
            end
            if (IR_Write) begin
                m_ir   <= mem_rdata;
                m_cnt  <= m_cnt + 1;
                m_cnt4 <= m_cnt4 + 1;
                m_link <= take_pc() ? target() : m_pc;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Compare process: every falling edge, all outputs against the model
    always @(negedge clk) begin
        chk("pc", pc_q, m_pc);
        chk("ir", ir_q, m_ir);
        chk("mdr", mdr_q, m_mdr);
        chk("aluout", aluout_q, m_alu);
        chk("link", link_q, m_link);
        chk("cnt", instr_cnt, m_cnt);
        chk("cnt4", b_cnt, m_cnt4);
        chk("err", align_err, m_err);
        chk("addr", mem_addr, IorD ? m_alu : m_pc);
        chk("fields", {op, rs, rt, rd, funct, imm, jidx},
            {m_ir[31:26], m_ir[25:21], m_ir[20:16], m_ir[15:11],
             m_ir[5:0], m_ir[15:0], m_ir[25:0]});
    end

    task automatic drive(input logic pcw, br, src, pcj, irw, iord, z,
                         input logic [31:0] ar, rdat);
        PC_Write = pcw; Branch = br; PC_Src = src; PC_J = pcj;
        IR_Write = irw; IorD = iord; alu_zero = z;
        alu_result = ar; mem_rdata = rdat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] ar);
        drive(0, 0, 0, 1, 0, 0, 0, ar, 32'h0);
    endtask

    // Mid-cycle asynchronous reset, released away from clock edges
    task automatic pulse_reset(input bit lit);
        #2 rst = 1'b0;
        #1;
        if (lit) begin
            chk("rst_pc", pc_q, 32'h0040_0000);
            chk("rst_ir", ir_q, 32'h0);
            chk("rst_cnt", instr_cnt, 32'h0);
            chk("rst_err", align_err, 1'b0);
            chk("rst_link", link_q, 32'h0);
        end
        @(posedge clk);
        #3 rst = 1'b1;
    endtask

    initial begin
        idle(32'h0);
        #12 rst = 1'b1;
        tick();
        chk("init_pc", pc_q, 32'h0040_0000);
        chk("init_cnt", instr_cnt, 32'h0);

        // Fetch
        drive(1, 0, 0, 1, 1, 0, 0, 32'h0040_0004, 32'h2008_0005);
        tick();
        chk("f_ir", ir_q, 32'h2008_0005);
        chk("f_op", op, 6'h08);
        chk("f_imm", imm, 16'h0005);
        chk("f_pc", pc_q, 32'h0040_0004);
        chk("f_link", link_q, 32'h0040_0004);
        chk("f_cnt", instr_cnt, 32'h1);

        // Branch taken then not taken
        idle(32'h0040_0020);
        tick();
        drive(0, 1, 1, 1, 0, 0, 1, 32'h0, 32'h0);
        tick();
        chk("br_taken", pc_q, 32'h0040_0020);
        drive(0, 1, 1, 1, 0, 0, 0, 32'h0040_0100, 32'h0);
        tick();
        chk("br_not", pc_q, 32'h0040_0020);

        // JAL fetch then jump
        drive(1, 0, 0, 1, 1, 0, 0, 32'h0040_0008, 32'h0C10_0010);
        tick();
        chk("j_jidx", jidx, 26'h010_0010);
        drive(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        chk("j_pc", pc_q, 32'h0040_0040);
        idle(32'h0);
        tick();
        chk("j_link1", link_q, 32'h0040_0008);
        tick();
        chk("j_link2", link_q, 32'h0040_0008);

        // Data access through aluout
        idle(32'h1001_0000);
        tick();
        drive(0, 0, 0, 1, 0, 1, 0, 32'h0, 32'hDEAD_BEEF);
        #1 chk("m_addr", mem_addr, 32'h1001_0000);
        tick();
        chk("m_mdr", mdr_q, 32'hDEAD_BEEF);

        // Misaligned PC load
        drive(1, 0, 0, 1, 0, 0, 0, 32'h0040_0006, 32'h0);
        tick();
        chk("a_pc", pc_q, 32'h0040_0006);
        chk("a_err", align_err, 1'b1);
        idle(32'h0040_0000);
        tick();
        tick();
        chk("a_hold", align_err, 1'b1);

        // Reset, then wrap the narrow counter
        pulse_reset(1);
        tick();
        drive(0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h1234_5678);
        repeat (16) tick();
        chk("wrap4", b_cnt, 4'h0);
        chk("cnt16", instr_cnt, 32'd16);
        idle(32'h0);
        tick();

        // Randomized strobes
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ar;
            ar = $urandom;
            if ($urandom_range(0, 7) != 0) ar[1:0] = 2'b00;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                  $urandom_range(0, 1), ar, $urandom);
            if ($urandom_range(0, 99) == 0) pulse_reset(0);
            tick();
        end

        idle(32'h0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
